icache_line_fetch: RTL and testbench
====================================

# icache_line_fetch

Direct-mapped instruction cache sitting between the IF stage and the shared SRAM line controller, on the requester side of the ICache refill handshake. It serves 32-bit instruction fetches from locally held 128-bit lines. On a miss it requests a whole line via `memory_valid_for_ICache`/`load_inst_addr`, installs the returned `inst_from_mem`, and replays the lookup. The SRAM controller gives DCache priority, so refill latency is unbounded and handled purely by handshake.

## Interface
- `INDEX_BITS`, default 8: line index width; 2^INDEX_BITS lines × 16 B.
- `LINE_WIDTH`, default 128: line width; fixed at 4 words.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `fetch_req` input 1: IF presents a fetch address this cycle.
- `fetch_addr` input 32: byte address; bits [1:0] ignored.
- `fetch_ready` output 1: combinational; a request is accepted at an edge where `fetch_req && fetch_ready`.
- `inst_valid` output 1: combinational; `inst` is valid for the held request.
- `inst` output 32: instruction word.
- `stall` input 1: downstream cannot take `inst` this cycle.
- `flush` input 1: redirect (EX_Branch | Pre_Branch); kills the held request.
- `memory_valid_for_ICache` output 1: registered line-refill request.
- `load_inst_addr` output 32: registered line address, low 4 bits zero.
- `memory_ready_for_ICache` input 1: one-cycle pulse; line data valid.
- `inst_from_mem` input 128: line; word k (byte offset 4k) is at [32k+31:32k].

## Operation
- Address split: offset = addr[3:2], index = addr[INDEX_BITS+3:4], tag = addr[31:INDEX_BITS+4].
- Storage: valid bit array, tag array, and data array, all register-based with combinational read.
- Request register: `req_v`, `req_addr`. It is loaded when a request is accepted and cleared when the response is consumed (`inst_valid && !stall`) without a new accept.
- `hit` = `req_v` && valid[idx] && tag[idx] == req tag.
- States:
  - RUN:
    - `inst_valid` = `hit`; `inst` = the selected word.
    - `fetch_ready` = !`req_v` || (`hit` && !`stall`).
    - If `req_v` && !`hit` && !`flush`: go to MISS. On the same edge set `memory_valid_for_ICache`=1 and `load_inst_addr` = {req_addr[31:4], 4'b0}.
  - MISS:
    - `fetch_ready`=0 and `inst_valid`=0.
    - `load_inst_addr` is held stable.
    - On an edge with `memory_ready_for_ICache`=1:
      - write data[idx] = `inst_from_mem`, tag[idx], and valid[idx]=1;
      - clear `memory_valid_for_ICache`;
      - return to RUN. The replayed lookup then hits.
- `memory_valid_for_ICache` must be low in the cycle after the ready pulse. This prevents the controller from re-launching from IDLE.
- Flush, highest priority, in any state:
  - `req_v` <= `fetch_req`, and `req_addr` <= `fetch_addr`. The redirect target is accepted in the flush cycle regardless of `fetch_ready`.
  - `inst_valid` is forced to 0 during the flush cycle.
  - In MISS: clear `memory_valid_for_ICache` and go to RUN.
  - If `memory_ready_for_ICache` coincides with `flush`, the line is still installed and only the request is dropped.
- Stall: with `hit` && `stall`, `inst` and `req` hold. Stall never blocks an in-progress refill.
- Refill during stall: a ready pulse that arrives while `stall`=1 still installs the line. The hit is presented after the return to RUN.
- Reset (`rst_n`=0 at edge):
  - all valid bits are cleared;
  - `req_v`=0 and state=RUN;
  - `memory_valid_for_ICache`=0 and `load_inst_addr`=0.
  - This applies mid-miss too; no response is pending afterwards.

## Timing
- Reset values: `memory_valid_for_ICache`=0, `load_inst_addr`=0. `inst_valid`=0 and `fetch_ready`=1, since `req_v`=0.
- Hit latency: accept at edge T; `inst_valid` is high during the cycle after T. Back-to-back hits sustain 1 fetch/cycle.
- Miss:
  - accept at edge T;
  - the miss is detected in cycle T+1;
  - `memory_valid_for_ICache` rises after edge T+1;
  - the ready pulse is sampled at edge R;
  - `inst_valid` is high in the cycle after R.
- `memory_valid_for_ICache` is high continuously from MISS entry until the ready or flush edge. `load_inst_addr` must not change while it is high.
- No new fetch is accepted while in MISS, except via `flush`.

## Test plan
- Cold miss:
  - Stimulus: after reset, fetch 0x8000_0014; after 10 cycles, pulse ready with line {W3,W2,W1,W0} = {0x4,0x3,0x2,0x1}.
  - Required: `load_inst_addr`=0x8000_0010 and valid held high; valid low the cycle after ready; next cycle `inst_valid`=1 with `inst`=0x2.
- Hits after fill: fetch 0x8000_0010, then 0x...18, then 0x...1C on consecutive cycles -> `inst`=0x1, 0x3, 0x4 on consecutive cycles; no memory request.
- Conflict:
  - Stimulus: with INDEX_BITS=8, fetch 0x8000_1010, which has the same index as 0x8000_0010.
  - Required: miss with `load_inst_addr`=0x8000_1010. After the fill, refetching 0x8000_0010 misses again.
- Stall: hold `stall`=1 for 3 cycles during a hit -> `inst` and `inst_valid` are stable and `fetch_ready`=0; the next request is accepted on the first non-stall cycle.
- Flush mid-miss:
  - Stimulus: `flush` plus `fetch_req`=0x8000_0200 while in MISS.
  - Required: `memory_valid_for_ICache` drops next cycle and a new miss for 0x8000_0200 follows.
  - Repeat with ready coinciding with flush: the old line is installed (later hit), and no `inst_valid` is produced for the old request.
- Reset mid-miss: `rst_n`=0 while `memory_valid_for_ICache`=1 -> valid=0 next cycle; a refetch of a previously filled address misses.

Source files
------------

// File: rtl/icache_line_fetch_if.sv
// Fetch-side and refill-side handshake bundle of the instruction cache.
// slave is the cache's view; master is the IF stage / SRAM controller side.
interface icache_line_fetch_if #(
  parameter int LINE_WIDTH = 128
);
  logic                  fetch_req;
  logic [31:0]           fetch_addr;
  logic                  fetch_ready;
  logic                  inst_valid;
  logic [31:0]           inst;
  logic                  stall;
  logic                  flush;
  logic                  memory_valid_for_ICache;
  logic [31:0]           load_inst_addr;
  logic                  memory_ready_for_ICache;
  logic [LINE_WIDTH-1:0] inst_from_mem;

  modport slave (
    input  fetch_req, fetch_addr, stall, flush,
    input  memory_ready_for_ICache, inst_from_mem,
    output fetch_ready, inst_valid, inst,
    output memory_valid_for_ICache, load_inst_addr
  );

  modport master (
    output fetch_req, fetch_addr, stall, flush,
    output memory_ready_for_ICache, inst_from_mem,
    input  fetch_ready, inst_valid, inst,
    input  memory_valid_for_ICache, load_inst_addr
  );
endinterface

// File: rtl/icache_line_fetch.sv
// Direct-mapped instruction cache: one held fetch request, hits answered the
// cycle after accept, misses refilled a whole line through a registered request.
module icache_line_fetch #(
  parameter int INDEX_BITS = 8,
  parameter int LINE_WIDTH = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  icache_line_fetch_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 4;

  typedef enum logic {S_RUN, S_MISS} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [LINE_WIDTH-1:0] r_data [LINES];
  logic                  r_req_v;
  logic [31:0]           r_req_addr;
  logic                  r_mem_valid;
  logic [31:0]           r_load_addr;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [1:0]            w_off;
  logic [LINE_WIDTH-1:0] w_line;
  logic [31:0]           w_word;
  logic                  w_hit;
  logic                  w_fetch_ready;
  logic                  w_inst_valid;
  logic                  w_miss_start;
  logic                  w_fill;
  logic                  w_accept;
  logic                  w_consume;
  logic                  w_unused_lsb;

  assign w_idx        = r_req_addr[INDEX_BITS+3:4];
  assign w_tag        = r_req_addr[31:INDEX_BITS+4];
  assign w_off        = r_req_addr[3:2];
  assign w_line       = r_data[w_idx];
  assign w_word       = w_line[{w_off, 5'b0} +: 32];
  assign w_hit        = r_req_v && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused_lsb = ^r_req_addr[1:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_ready = 1'b0;
    w_inst_valid  = 1'b0;
    w_miss_start  = 1'b0;
    w_fill        = 1'b0;
    case (r_state)
      S_RUN: begin
        w_inst_valid  = w_hit && !bus.flush;
        w_fetch_ready = !r_req_v || (w_hit && !bus.stall);
        if (r_req_v && !w_hit && !bus.flush) begin
          w_state_nxt  = S_MISS;
          w_miss_start = 1'b1;
        end
      end
      S_MISS: begin
        // A returning line is installed even when a redirect drops its request.
        w_fill = bus.memory_ready_for_ICache;
        if (bus.flush || bus.memory_ready_for_ICache) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign w_accept  = bus.fetch_req && w_fetch_ready;
  assign w_consume = w_inst_valid && !bus.stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirect target is taken in the flush cycle even while fetch_ready is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_v    <= 1'b0;
      r_req_addr <= '0;
    end else if (bus.flush) begin
      r_req_v    <= bus.fetch_req;
      r_req_addr <= bus.fetch_addr;
    end else if (w_accept) begin
      r_req_v    <= 1'b1;
      r_req_addr <= bus.fetch_addr;
    end else if (w_consume) begin
      r_req_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_valid <= 1'b0;
      r_load_addr <= '0;
    end else if (w_miss_start) begin
      r_mem_valid <= 1'b1;
      r_load_addr <= {r_req_addr[31:4], 4'b0};
    end else if ((r_state == S_MISS) && (bus.flush || bus.memory_ready_for_ICache)) begin
      r_mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= bus.inst_from_mem;
    end
  end

  assign bus.fetch_ready             = w_fetch_ready;
  assign bus.inst_valid              = w_inst_valid;
  assign bus.inst                    = w_word;
  assign bus.memory_valid_for_ICache = r_mem_valid;
  assign bus.load_inst_addr          = r_load_addr;
endmodule

// File: tb/tb_icache_line_fetch.sv
// Bench for icache_line_fetch: directed scenarios plus random fetches checked
// against a line-residency model of a direct-mapped cache.
module tb_icache_line_fetch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icache_line_fetch_if #(.LINE_WIDTH(128)) bus();

  icache_line_fetch #(.INDEX_BITS(8), .LINE_WIDTH(128)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_valid [256];
  logic [31:0] m_line  [256];
  logic [31:0] hs      [3];
  logic [31:0] hi_pool [3];

  function automatic logic [127:0] line_of(input logic [31:0] la);
    logic [127:0] l;
    if (la == 32'h8000_0010) return {32'h4, 32'h3, 32'h2, 32'h1};
    for (int k = 0; k < 4; k++)
      l[32*k +: 32] = (la * 32'h9E37_79B1) + 32'(k) * 32'h0101_0101 + 32'h0000_00AB;
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [127:0] l;
    l = line_of({a[31:4], 4'b0});
    return l[32*a[3:2] +: 32];
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[11:4]] && (m_line[a[11:4]] == {a[31:4], 4'b0});
  endfunction

  function automatic void m_install(input logic [31:0] la);
    m_valid[la[11:4]] = 1'b1;
    m_line[la[11:4]]  = la;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_accept(input logic [31:0] addr);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    samp();
    chk("fetch_ready_at_accept", bus.fetch_ready, 1);
    step();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = $urandom;
  endtask

  task automatic miss_front(input logic [31:0] la, input int lat);
    samp();
    chk("inst_valid_at_detect", bus.inst_valid, 0);
    chk("mem_valid_at_detect", bus.memory_valid_for_ICache, 0);
    step();
    repeat (lat) begin
      samp();
      chk("mem_valid_held", bus.memory_valid_for_ICache, 1);
      chk("load_inst_addr", bus.load_inst_addr, la);
      chk("fetch_ready_in_miss", bus.fetch_ready, 0);
      chk("inst_valid_in_miss", bus.inst_valid, 0);
      step();
    end
  endtask

  // Starts right after the accept edge; finishes once the response is consumed.
  task automatic complete(input logic [31:0] addr, input int lat, input int nstall, input bit stall_on_ready);
    logic [31:0] la;
    logic [31:0] exp;
    la  = {addr[31:4], 4'b0};
    exp = word_of(addr);
    if (m_hit(addr)) begin
      repeat (nstall) begin
        bus.stall = 1'b1;
        samp();
        chk("hit_valid_stalled", bus.inst_valid, 1);
        chk("hit_inst_stalled", bus.inst, exp);
        chk("fetch_ready_stalled", bus.fetch_ready, 0);
        chk("no_mem_req_on_hit", bus.memory_valid_for_ICache, 0);
        step();
      end
      bus.stall = 1'b0;
      samp();
      chk("hit_valid", bus.inst_valid, 1);
      chk("hit_inst", bus.inst, exp);
      chk("fetch_ready_on_hit", bus.fetch_ready, 1);
      chk("no_mem_req_on_hit", bus.memory_valid_for_ICache, 0);
      step();
    end else begin
      miss_front(la, lat);
      bus.memory_ready_for_ICache = 1'b1;
      bus.inst_from_mem           = line_of(la);
      bus.stall                   = stall_on_ready;
      samp();
      chk("mem_valid_at_ready", bus.memory_valid_for_ICache, 1);
      step();
      bus.memory_ready_for_ICache = 1'b0;
      bus.inst_from_mem           = {$urandom, $urandom, $urandom, $urandom};
      m_install(la);
      samp();
      chk("mem_valid_after_ready", bus.memory_valid_for_ICache, 0);
      chk("refill_valid", bus.inst_valid, 1);
      chk("refill_inst", bus.inst, exp);
      if (stall_on_ready) begin
        chk("fetch_ready_stalled", bus.fetch_ready, 0);
        step();
        bus.stall = 1'b0;
        samp();
        chk("refill_valid_after_stall", bus.inst_valid, 1);
        chk("refill_inst_after_stall", bus.inst, exp);
      end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    hs[0] = 32'h8000_0010; hs[1] = 32'h8000_0018; hs[2] = 32'h8000_001C;
    hi_pool[0] = 32'h8000_0000; hi_pool[1] = 32'h8000_1000; hi_pool[2] = 32'h4000_2000;
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = '0;
    end
    rst_n                       = 1'b0;
    bus.fetch_req               = 1'b0;
    bus.fetch_addr              = '0;
    bus.stall                   = 1'b0;
    bus.flush                   = 1'b0;
    bus.memory_ready_for_ICache = 1'b0;
    bus.inst_from_mem           = '0;
    repeat (3) step();
    rst_n = 1'b1;
    samp();
    chk("reset_mem_valid", bus.memory_valid_for_ICache, 0);
    chk("reset_load_addr", bus.load_inst_addr, 0);
    chk("reset_inst_valid", bus.inst_valid, 0);
    chk("reset_fetch_ready", bus.fetch_ready, 1);
    step();

    // Cold miss, then back-to-back hits in the filled line.
    do_accept(32'h8000_0014);
    complete(32'h8000_0014, 10, 0, 1'b0);
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = hs[i];
      end else begin
        bus.fetch_req = 1'b0;
      end
      samp();
      if (i > 0) begin
        chk("stream_valid", bus.inst_valid, 1);
        chk("stream_inst", bus.inst, word_of(hs[i-1]));
        chk("stream_no_mem_req", bus.memory_valid_for_ICache, 0);
      end
      if (i < 3) chk("stream_fetch_ready", bus.fetch_ready, 1);
      step();
    end

    // Same index, different tag: evicts and re-misses.
    do_accept(32'h8000_1010);
    complete(32'h8000_1010, 3, 0, 1'b0);
    do_accept(32'h8000_0010);
    complete(32'h8000_0010, 2, 0, 1'b1);

    // Stall holds a hit; next request accepted on the first unstalled cycle.
    do_accept(32'h8000_0014);
    bus.stall = 1'b1;
    repeat (3) begin
      samp();
      chk("stall_valid", bus.inst_valid, 1);
      chk("stall_inst", bus.inst, 32'h2);
      chk("stall_fetch_ready", bus.fetch_ready, 0);
      step();
    end
    bus.stall      = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h8000_001C;
    samp();
    chk("unstall_fetch_ready", bus.fetch_ready, 1);
    chk("unstall_inst", bus.inst, 32'h2);
    step();
    bus.fetch_req = 1'b0;
    samp();
    chk("after_stall_valid", bus.inst_valid, 1);
    chk("after_stall_inst", bus.inst, 32'h4);
    step();

    // Flush while waiting for a line redirects to a new miss.
    do_accept(32'h8000_0300);
    miss_front(32'h8000_0300, 3);
    bus.flush      = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h8000_0200;
    samp();
    chk("flush_inst_valid", bus.inst_valid, 0);
    step();
    bus.flush     = 1'b0;
    bus.fetch_req = 1'b0;
    complete(32'h8000_0200, 4, 0, 1'b0);

    // Flush coinciding with the ready pulse: line kept, request dropped.
    do_accept(32'h8000_0400);
    miss_front(32'h8000_0400, 2);
    bus.flush                   = 1'b1;
    bus.memory_ready_for_ICache = 1'b1;
    bus.inst_from_mem           = line_of(32'h8000_0400);
    samp();
    chk("flush_ready_inst_valid", bus.inst_valid, 0);
    step();
    bus.flush                   = 1'b0;
    bus.memory_ready_for_ICache = 1'b0;
    bus.inst_from_mem           = {$urandom, $urandom, $urandom, $urandom};
    m_install(32'h8000_0400);
    repeat (3) begin
      samp();
      chk("dropped_req_no_valid", bus.inst_valid, 0);
      chk("dropped_req_no_mem", bus.memory_valid_for_ICache, 0);
      chk("dropped_req_ready", bus.fetch_ready, 1);
      step();
    end
    do_accept(32'h8000_0404);
    complete(32'h8000_0404, 2, 0, 1'b0);

    // Reset in the middle of a miss forgets every line.
    do_accept(32'h8000_0500);
    miss_front(32'h8000_0500, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    samp();
    chk("midmiss_rst_mem_valid", bus.memory_valid_for_ICache, 0);
    chk("midmiss_rst_load_addr", bus.load_inst_addr, 0);
    chk("midmiss_rst_inst_valid", bus.inst_valid, 0);
    chk("midmiss_rst_fetch_ready", bus.fetch_ready, 1);
    step();
    do_accept(32'h8000_0010);
    complete(32'h8000_0010, 2, 0, 1'b0);

    // Random fetches over a small pool of conflicting lines.
    repeat (60) begin
      logic [31:0] a;
      a = hi_pool[$urandom_range(0, 2)] + (32'($urandom_range(0, 3)) << 4)
        + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      do_accept(a);
      complete(a, $urandom_range(1, 6), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        samp();
        chk("idle_inst_valid", bus.inst_valid, 0);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
